// File: rtl/pcm_frame_packer.sv
// Multichannel PCM frame packer: snapshots N channel samples and streams them as
// an optional sequence header followed by one word per channel, with overrun tracking.
module pcm_frame_packer #(
    parameter int N      = 20,
    parameter int W      = 16,
    parameter int HEADER = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_in_valid,
    input  logic [N*W-1:0] i_in_data,
    input  logic           i_out_ready,
    input  logic           i_clr_ovr,
    output logic [W-1:0]   o_out_data,
    output logic           o_out_valid,
    output logic           o_out_first,
    output logic           o_out_last,
    output logic           o_overrun,
    output logic [7:0]     o_drop_cnt
);

    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [1:0]    ST_IDLE  = 2'd0;
    localparam logic [1:0]    ST_HDR   = 2'd1;
    localparam logic [1:0]    ST_DATA  = 2'd2;
    localparam logic [1:0]    ST_START = (HEADER != 0) ? ST_HDR : ST_DATA;

    logic [1:0]     r_state;
    logic [IW-1:0]  r_idx;
    logic [11:0]    r_seq;
    logic [N*W-1:0] r_snap;
    logic           r_overrun;
    logic [7:0]     r_drop_cnt;
    logic [W-1:0]   r_out_data;
    logic           r_out_valid;
    logic           r_out_first;
    logic           r_out_last;

    logic           w_xfer;
    logic           w_load;
    logic           w_drop;
    logic [1:0]     w_state_nxt;
    logic [IW-1:0]  w_idx_nxt;
    logic [11:0]    w_seq_nxt;
    logic [N*W-1:0] w_snap_nxt;
    logic [W-1:0]   w_hdr;
    logic [W-1:0]   w_data_nxt;
    logic           w_valid_nxt;
    logic           w_first_nxt;
    logic           w_last_nxt;

    // Next-state logic: frame acceptance, word advance and drop detection
    always_comb begin
        w_xfer      = r_out_valid & i_out_ready;
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_seq_nxt   = r_seq;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_in_valid) begin
                    w_load      = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HDR: begin
                w_drop = i_in_valid;
                if (w_xfer) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_state_nxt = ST_HDR;
                end
            end
            ST_DATA: begin
                if (w_xfer && (r_idx == LAST_IDX)) begin
                    // A new frame arriving on the final transfer starts with no idle bubble
                    w_seq_nxt = r_seq + 12'd1;
                    w_idx_nxt = '0;
                    if (i_in_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_drop = i_in_valid;
                    if (w_xfer) begin
                        w_idx_nxt = r_idx + IW'(1);
                    end else begin
                        w_idx_nxt = r_idx;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    // Output word for the upcoming state, so outputs leave the flops directly
    always_comb begin
        w_snap_nxt = w_load ? i_in_data : r_snap;
        w_hdr        = '0;
        w_hdr[15:0]  = {4'hA, w_seq_nxt};
        w_data_nxt   = '0;
        w_valid_nxt  = 1'b0;
        w_first_nxt  = 1'b0;
        w_last_nxt   = 1'b0;
        case (w_state_nxt)
            ST_HDR: begin
                w_data_nxt  = w_hdr;
                w_valid_nxt = 1'b1;
                w_first_nxt = 1'b1;
            end
            ST_DATA: begin
                w_data_nxt  = w_snap_nxt[int'(w_idx_nxt)*W +: W];
                w_valid_nxt = 1'b1;
                w_first_nxt = (HEADER == 0) && (w_idx_nxt == '0);
                w_last_nxt  = (w_idx_nxt == LAST_IDX);
            end
            default: begin
                w_data_nxt  = '0;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Frame state, channel index, sequence number and snapshot bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_seq   <= 12'd0;
            r_snap  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_seq   <= w_seq_nxt;
            r_snap  <= w_snap_nxt;
        end
    end

    // Registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_out_data  <= w_data_nxt;
            r_out_valid <= w_valid_nxt;
            r_out_first <= w_first_nxt;
            r_out_last  <= w_last_nxt;
        end
    end

    // Overrun flag and saturating drop counter; a drop wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
            if (i_clr_ovr) begin
                r_drop_cnt <= 8'd1;
            end else if (r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end else begin
                r_drop_cnt <= r_drop_cnt;
            end
        end else if (i_clr_ovr) begin
            r_overrun  <= 1'b0;
            r_drop_cnt <= 8'd0;
        end else begin
            r_overrun  <= r_overrun;
            r_drop_cnt <= r_drop_cnt;
        end
    end

    assign o_out_data  = r_out_data;
    assign o_out_valid = r_out_valid;
    assign o_out_first = r_out_first;
    assign o_out_last  = r_out_last;
    assign o_overrun   = r_overrun;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_pcm_frame_packer.sv
// Bench for pcm_frame_packer: directed vector table, hand sequences for multi-cycle
// corners, and randomized traffic checked against a queue-based frame model.
module tb_pcm_frame_packer;

    localparam int N = 20;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // main DUT: N=20, HEADER=1
    logic           m_vin, m_rdy, m_clr;
    logic [N*W-1:0] m_data;
    logic [W-1:0]   m_odata;
    logic           m_ovalid, m_ofirst, m_olast, m_ovr;
    logic [7:0]     m_cnt;
    // headerless DUT
    logic           z_vin;
    logic [N*W-1:0] z_data;
    logic [W-1:0]   z_odata;
    logic           z_ovalid, z_ofirst, z_olast, z_ovr;
    logic [7:0]     z_cnt;
    // single-channel DUT for sequence wrap
    logic           s_vin;
    logic [W-1:0]   s_data;
    logic [W-1:0]   s_odata;
    logic           s_ovalid, s_ofirst, s_olast, s_ovr;
    logic [7:0]     s_cnt;

    pcm_frame_packer #(.N(N), .W(W), .HEADER(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_in_valid(m_vin), .i_in_data(m_data),
        .i_out_ready(m_rdy), .i_clr_ovr(m_clr), .o_out_data(m_odata),
        .o_out_valid(m_ovalid), .o_out_first(m_ofirst), .o_out_last(m_olast),
        .o_overrun(m_ovr), .o_drop_cnt(m_cnt));

    pcm_frame_packer #(.N(N), .W(W), .HEADER(0)) dut_z (
        .clk(clk), .rst_n(rst_n), .i_in_valid(z_vin), .i_in_data(z_data),
        .i_out_ready(1'b1), .i_clr_ovr(1'b0), .o_out_data(z_odata),
        .o_out_valid(z_ovalid), .o_out_first(z_ofirst), .o_out_last(z_olast),
        .o_overrun(z_ovr), .o_drop_cnt(z_cnt));

    pcm_frame_packer #(.N(1), .W(W), .HEADER(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .i_in_valid(s_vin), .i_in_data(s_data),
        .i_out_ready(1'b1), .i_clr_ovr(1'b0), .o_out_data(s_odata),
        .o_out_valid(s_ovalid), .o_out_first(s_ofirst), .o_out_last(s_olast),
        .o_overrun(s_ovr), .o_drop_cnt(s_cnt));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_main(input string tag, input bit ev, input logic [15:0] ed,
                            input bit ef, input bit el, input bit eo, input logic [7:0] ec);
        chk({tag, " valid"}, 32'(m_ovalid), 32'(ev));
        chk({tag, " data"},  32'(m_odata),  32'(ed));
        chk({tag, " first"}, 32'(m_ofirst), 32'(ef));
        chk({tag, " last"},  32'(m_olast),  32'(el));
        chk({tag, " ovr"},   32'(m_ovr),    32'(eo));
        chk({tag, " cnt"},   32'(m_cnt),    32'(ec));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit vin; bit rdy; bit clr; bit alt;
        bit ev; logic [15:0] ed; bit ef; bit el; bit eo; logic [7:0] ec;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(bit vin, bit rdy, bit clr, bit alt, bit ev, logic [15:0] ed,
                                bit ef, bit el, bit eo, logic [7:0] ec);
        vec_t v;
        v.vin = vin; v.rdy = rdy; v.clr = clr; v.alt = alt;
        v.ev = ev; v.ed = ed; v.ef = ef; v.el = el; v.eo = eo; v.ec = ec;
        tbl.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    typedef struct { logic [15:0] d; bit f; bit l; } word_t;
    word_t mq[$];
    int    mseq;
    bit    movr;
    int    mcnt;

    task automatic model_step(input bit vin, input logic [N*W-1:0] din, input bit rdy, input bit clr);
        bit    drop;
        word_t w;
        drop = 1'b0;
        if (mq.size() > 0 && rdy) begin
            if (mq[0].l) mseq = (mseq + 1) % 4096;
            mq.delete(0);
        end
        if (vin) begin
            if (mq.size() == 0) begin
                w.d = {4'hA, 12'(mseq)}; w.f = 1'b1; w.l = 1'b0;
                mq.push_back(w);
                for (int k = 0; k < N; k++) begin
                    w.d = din[k*W +: W]; w.f = 1'b0; w.l = (k == N - 1);
                    mq.push_back(w);
                end
            end else begin
                drop = 1'b1;
            end
        end
        if (drop) begin
            movr = 1'b1;
            mcnt = clr ? 1 : ((mcnt < 255) ? mcnt + 1 : 255);
        end else if (clr) begin
            movr = 1'b0;
            mcnt = 0;
        end
    endtask

    task automatic rand_cycle(input bit vin, input bit rdy, input bit clr);
        m_vin = vin; m_rdy = rdy; m_clr = clr;
        for (int k = 0; k < N; k++) m_data[k*W +: W] = 16'($urandom);
        model_step(vin, m_data, rdy, clr);
        tick();
        if (mq.size() > 0)
            chk_main("rand", 1'b1, mq[0].d, mq[0].f, mq[0].l, movr, 8'(mcnt));
        else
            chk_main("rand", 1'b0, 16'h0000, 1'b0, 1'b0, movr, 8'(mcnt));
    endtask

    logic [N*W-1:0] pat_a, pat_b;

    initial begin
        rst_n = 1'b1;
        m_vin = 1'b0; m_rdy = 1'b1; m_clr = 1'b0; m_data = '0;
        z_vin = 1'b0; z_data = '0;
        s_vin = 1'b0; s_data = 16'h0BEE;
        for (int k = 0; k < N; k++) begin
            pat_a[k*W +: W] = 16'h0100 + 16'(k);
            pat_b[k*W +: W] = 16'hFFFF;
            z_data[k*W +: W] = 16'h0200 + 16'(k);
        end
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_main("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        rst_n = 1'b1;

        // frame 0: basic
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA000, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < N; k++)
            add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100 + 16'(k), 1'b0, (k == N - 1), 1'b0, 8'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        // frame 1: backpressure on channel 5 for 7 cycles
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA001, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 6; k++)
            add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100 + 16'(k), 1'b0, 1'b0, 1'b0, 8'd0);
        for (int r = 0; r < 7; r++)
            add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0105, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 6; k < N; k++)
            add(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0100 + 16'(k), 1'b0, (k == N - 1), 1'b0, 8'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        // frame 2: overrun at word 10 with different input data
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA002, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < N; k++)
            add((k == 9), 1'b1, 1'b0, (k == 9), 1'b1, 16'h0100 + 16'(k), 1'b0, (k == N - 1),
                (k >= 9), (k >= 9) ? 8'd1 : 8'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        // frame 3: drop, then drop coincident with clear
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16'hA003, 1'b1, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < N; k++)
            add((k == 2 || k == 3), 1'b1, (k == 3), (k == 2 || k == 3), 1'b1, 16'h0100 + 16'(k),
                1'b0, (k == N - 1), (k >= 2), (k >= 2) ? 8'd1 : 8'd0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 8'd1);

        foreach (tbl[i]) begin
            m_vin = tbl[i].vin; m_rdy = tbl[i].rdy; m_clr = tbl[i].clr;
            m_data = tbl[i].alt ? pat_b : pat_a;
            tick();
            chk_main($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ef, tbl[i].el,
                     tbl[i].eo, tbl[i].ec);
        end
        m_clr = 1'b0;

        // back-to-back: new frame on the last transfer, no idle cycle
        m_data = pat_a; m_rdy = 1'b1; m_vin = 1'b1;
        tick();
        chk_main("b2b hdr0", 1'b1, 16'hA004, 1'b1, 1'b0, 1'b1, 8'd1);
        m_vin = 1'b0;
        repeat (N) tick();
        chk_main("b2b last", 1'b1, 16'h0113, 1'b0, 1'b1, 1'b1, 8'd1);
        m_vin = 1'b1;
        tick();
        chk_main("b2b hdr1", 1'b1, 16'hA005, 1'b1, 1'b0, 1'b1, 8'd1);
        m_vin = 1'b0;
        repeat (N + 1) tick();
        chk("b2b drain valid", 32'(m_ovalid), 32'd0);

        // reset mid-frame
        m_vin = 1'b1;
        tick();
        m_vin = 1'b0;
        repeat (8) tick();
        chk("pre-reset valid", 32'(m_ovalid), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_main("async reset", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        m_vin = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_main("post-reset hdr", 1'b1, 16'hA000, 1'b1, 1'b0, 1'b0, 8'd0);
        m_vin = 1'b0;
        repeat (N + 1) tick();
        chk("post-reset drain", 32'(m_ovalid), 32'd0);

        // randomized traffic against the model
        do_reset();
        mq.delete(); mseq = 0; movr = 1'b0; mcnt = 0;
        for (int c = 0; c < 3000; c++)
            rand_cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 9) < 7),
                       ($urandom_range(0, 99) == 0));
        // saturation of the drop counter under stalled output
        for (int c = 0; c < 300; c++) rand_cycle(1'b1, 1'b0, 1'b0);
        chk("drop saturate", 32'(m_cnt), 32'd255);
        rand_cycle(1'b0, 1'b1, 1'b1);
        for (int c = 0; c < 25; c++) rand_cycle(1'b0, 1'b1, 1'b0);

        // headerless frame
        z_vin = 1'b1;
        tick();
        z_vin = 1'b0;
        for (int i = 0; i <= N; i++) begin
            if (i < N) begin
                chk($sformatf("hdr0 valid%0d", i), 32'(z_ovalid), 32'd1);
                chk($sformatf("hdr0 data%0d", i), 32'(z_odata), 32'h0200 + 32'(i));
                chk($sformatf("hdr0 first%0d", i), 32'(z_ofirst), 32'(i == 0));
                chk($sformatf("hdr0 last%0d", i), 32'(z_olast), 32'(i == N - 1));
            end else begin
                chk("hdr0 end valid", 32'(z_ovalid), 32'd0);
            end
            tick();
        end

        // sequence wrap over 4096 back-to-back frames (single channel)
        s_vin = 1'b1;
        tick();
        for (int f = 0; f <= 4096; f++) begin
            chk($sformatf("wrap hdr%0d", f), 32'({s_ovalid, s_ofirst, s_odata}),
                32'({1'b1, 1'b1, 4'hA, 12'(f % 4096)}));
            s_vin = 1'b0;
            tick();
            if (f == 0) chk("wrap ch0", 32'({s_olast, s_odata}), 32'({1'b1, 16'h0BEE}));
            s_vin = 1'b1;
            tick();
        end
        s_vin = 1'b0;
        repeat (3) tick();
        chk("wrap no drop", 32'({s_ovr, s_cnt}), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
